rr_mux4_arbiter: RTL

//   Round-robin arbiter sharing one 4:1 mux datapath among four requesters.

---
 rtl/rr_mux4_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter steering one registered 4:1 data mux among four requesters.
// Define HOLD_TIMEOUT_EN to force a handover after MAX_HOLD cycles under contention.
module rr_mux4_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [4*DATA_W-1:0] j,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] g,
  output logic              g_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_mux4_arbiter: MAX_HOLD must be in 1..255");
  end

  state_t     state, state_next;
  logic [1:0] last, last_next;
  logic [1:0] sel_next;
  logic [3:0] others;
  logic [2:0] pick;

  // Lowest-distance requester after 'from'; 'from' itself is checked last.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [2:0] best;
    logic [1:0] cand;
    best = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      cand = from + 2'(i);
      if (r[cand]) best = {1'b1, cand};
    end
    return best;
  endfunction

  assign others = req & ~(4'b0001 << last);

`ifdef HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_next;
`endif

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    last_next  = last;
    sel_next   = sel;
`ifdef HOLD_TIMEOUT_EN
    hold_next  = hold_cnt;
`endif
    // While busy the owner is masked, so a winner is always a different lane.
    pick = rr_pick((state == IDLE) ? req : others, last);

    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_next = BUSY;
          last_next  = pick[1:0];
          sel_next   = pick[1:0];
`ifdef HOLD_TIMEOUT_EN
          hold_next  = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[last]) begin
          if (pick[2]) begin
            last_next = pick[1:0];
            sel_next  = pick[1:0];
`ifdef HOLD_TIMEOUT_EN
            hold_next = '0;
`endif
          end else begin
            state_next = IDLE;
          end
        end
`ifdef HOLD_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          hold_next = '0;
          if (pick[2]) begin
            last_next = pick[1:0];
            sel_next  = pick[1:0];
          end
        end else if (hold_cnt != 8'hff) begin
          hold_next = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'd3;
      sel     <= 2'd0;
      gnt     <= 4'b0000;
      g       <= '0;
      g_valid <= 1'b0;
    end else begin
      state   <= state_next;
      last    <= last_next;
      sel     <= sel_next;
      gnt     <= (state_next == BUSY) ? (4'b0001 << last_next) : 4'b0000;
      g_valid <= (state_next == BUSY);
      // g is loaded only while owned, so it keeps its last word through idle.
      if (state_next == BUSY) g <= j[int'(sel_next)*DATA_W +: DATA_W];
    end
  end

`ifdef HOLD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_next;
  end
`endif

endmodule
